// File: rtl/fb_pkg.sv
// Framebuffer geometry and shared types for the framebuffer write/read paths.
package fb_pkg;

  localparam int FB_WIDTH        = 1024;
  localparam int FB_HEIGHT       = 768;
  localparam int PIXEL_W         = 24;
  localparam int PIXELS_PER_WORD = 32;

  localparam int WORD_BITS    = PIXEL_W * PIXELS_PER_WORD;
  localparam int FB_ADDR_STEP = 16;
  localparam int FB_WORDS     = (FB_WIDTH * FB_HEIGHT) / PIXELS_PER_WORD;
  localparam int FB_BYTES     = FB_WORDS * FB_ADDR_STEP;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ERR,
    GAP
  } wr_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie the input not granted last wins, and
// the priority pointer only moves when the caller reports the grant was taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    gnt_id = ptr_q;
    gnt    = 2'b00;
    ptr_d  = ptr_q;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = ptr_q;
    endcase
    if (req != 2'b00) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
    if (accept) begin
      ptr_d = ~gnt_id;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port between the packet writer (r0) and the
// fill/draw engine (r1): one accept at a time, range check, strobe, then pacing.
module fb_write_arbiter #(
  parameter int DATA_W     = 768,
  parameter int ADDR_W     = 32,
  parameter int ADDR_STEP  = 16,
  parameter int FB_WORDS   = fb_pkg::FB_WORDS,
  parameter int GAP_CYCLES = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_ready,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_data,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_data,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              m_write_ram,
  output logic [DATA_W-1:0] m_write_data,
  output logic [ADDR_W-1:0] m_write_address,
  output logic              grant_id,
  output logic              err_range,
  output logic [15:0]       wr_count
);

  import fb_pkg::*;

  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(FB_WORDS * ADDR_STEP);
  localparam logic [ADDR_W-1:0] ADDR_ALIGN = ADDR_W'(ADDR_STEP);

  wr_state_e         state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              m_write_ram_q, m_write_ram_d;
  logic [DATA_W-1:0] m_write_data_q, m_write_data_d;
  logic [ADDR_W-1:0] m_write_address_q, m_write_address_d;
  logic              grant_id_q, grant_id_d;
  logic              err_range_q, err_range_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [1:0]        arb_gnt;
  logic              arb_id;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_legal;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req    ({r1_valid, r0_valid}),
    .accept (accept),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // Ready is combinational so the handshake completes in the same cycle the
  // arbiter picks a winner; reset suppresses it immediately.
  assign can_accept = (state_q == IDLE) && mem_ready && !reset;
  assign r0_ready   = can_accept && arb_gnt[0];
  assign r1_ready   = can_accept && arb_gnt[1];
  assign accept     = r0_ready || r1_ready;

  assign sel_data  = arb_id ? r1_data : r0_data;
  assign sel_addr  = arb_id ? r1_addr : r0_addr;
  assign sel_legal = (sel_addr < ADDR_LIMIT) && ((sel_addr % ADDR_ALIGN) == '0);

  always_comb begin
    state_d           = state_q;
    gap_cnt_d         = gap_cnt_q;
    m_write_ram_d     = 1'b0;
    m_write_data_d    = m_write_data_q;
    m_write_address_d = m_write_address_q;
    grant_id_d        = grant_id_q;
    err_range_d       = 1'b0;
    wr_count_d        = wr_count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_id_d = arb_id;
          if (sel_legal) begin
            state_d           = ISSUE;
            m_write_ram_d     = 1'b1;
            m_write_data_d    = sel_data;
            m_write_address_d = sel_addr;
            wr_count_d        = wr_count_q + 16'd1;
          end else begin
            // Bad addresses are still consumed so the requester never stalls.
            state_d     = ERR;
            err_range_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        gap_cnt_d = '0;
        state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      ERR: begin
        state_d = IDLE;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the wide data/address registers are ports, so they are reset along with the control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      gap_cnt_q         <= '0;
      m_write_ram_q     <= 1'b0;
      m_write_data_q    <= '0;
      m_write_address_q <= '0;
      grant_id_q        <= 1'b0;
      err_range_q       <= 1'b0;
      wr_count_q        <= '0;
    end else begin
      state_q           <= state_d;
      gap_cnt_q         <= gap_cnt_d;
      m_write_ram_q     <= m_write_ram_d;
      m_write_data_q    <= m_write_data_d;
      m_write_address_q <= m_write_address_d;
      grant_id_q        <= grant_id_d;
      err_range_q       <= err_range_d;
      wr_count_q        <= wr_count_d;
    end
  end

  // A reset landing in the strobe cycle must not let the write reach memory.
  assign m_write_ram     = m_write_ram_q && !reset;
  assign err_range       = err_range_q && !reset;
  assign m_write_data    = m_write_data_q;
  assign m_write_address = m_write_address_q;
  assign grant_id        = grant_id_q;
  assign wr_count        = wr_count_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a timing-level reference model.
module tb_fb_write_arbiter;

  localparam int DATA_W = 768;
  localparam int ADDR_W = 32;
  localparam int GAP    = 100;
  localparam int PERIOD = GAP + 2;
  localparam int LIMIT  = 393216;

  logic              clk = 1'b0;
  logic              reset, mem_ready;
  logic              r0_valid, r0_ready, r1_valid, r1_ready;
  logic [DATA_W-1:0] r0_data, r1_data, m_write_data;
  logic [ADDR_W-1:0] r0_addr, r1_addr, m_write_address;
  logic              m_write_ram, grant_id, err_range;
  logic [15:0]       wr_count;

  always #5 clk = ~clk;

  fb_write_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .mem_ready       (mem_ready),
    .r0_valid        (r0_valid),
    .r0_ready        (r0_ready),
    .r0_data         (r0_data),
    .r0_addr         (r0_addr),
    .r1_valid        (r1_valid),
    .r1_ready        (r1_ready),
    .r1_data         (r1_data),
    .r1_addr         (r1_addr),
    .m_write_ram     (m_write_ram),
    .m_write_data    (m_write_data),
    .m_write_address (m_write_address),
    .grant_id        (grant_id),
    .err_range       (err_range),
    .wr_count        (wr_count)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: the port is free from cycle free_at on; prio names the
  // requester that wins a tie; exp_* are the outputs expected this cycle.
  int                cyc     = 0;
  int                free_at = 0;
  logic              prio    = 1'b0;
  logic              exp_ram = 1'b0;
  logic              exp_err = 1'b0;
  logic              exp_gid = 1'b0;
  logic [15:0]       exp_cnt = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic [ADDR_W-1:0] exp_addr = '0;

  // Requester stubs: pN = write pending, holdN = re-arm immediately after accept.
  logic              p0 = 1'b0, p1 = 1'b0, hold0 = 1'b0, hold1 = 1'b0;
  logic [ADDR_W-1:0] a0 = '0, a1 = '0;
  logic [DATA_W-1:0] d0 = '0, d1 = '0;
  logic              mr = 1'b1, rst = 1'b1;

  // Handshakes as observed on the DUT ports.
  int   acc_cyc[$];
  logic acc_win[$];

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h (low 256 bits)", tag, obs[255:0], expv[255:0]);
    end
  endtask

  task automatic check_acc(input string tag, input int idx, input int exp_cyc, input logic exp_win);
    vecs++;
    assert (acc_cyc.size() > idx) else begin
      errs++;
      $error("FAIL %s: observed no handshake #%0d, expected one at cycle %0d", tag, idx, exp_cyc);
    end
    if (acc_cyc.size() > idx) begin
      check({tag, "_cycle"}, DATA_W'(acc_cyc[idx]), DATA_W'(exp_cyc));
      check({tag, "_winner"}, DATA_W'(acc_win[idx]), DATA_W'(exp_win));
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_addr();
    logic [ADDR_W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = ADDR_W'(LIMIT) + ADDR_W'($urandom_range(0, 1000) * 16);
      1:       v = ADDR_W'($urandom_range(0, 24575) * 16) | ADDR_W'($urandom_range(1, 15));
      2:       v = 32'hFFFF_FFF0;
      default: v = ADDR_W'($urandom_range(0, 24575) * 16);
    endcase
    return v;
  endfunction

  // One clock cycle: drive, sample at the falling edge, check, advance model.
  task automatic tick();
    logic w0, w1, win, legal;
    logic [ADDR_W-1:0] a;
    reset = rst; mem_ready = mr;
    r0_valid = p0; r0_addr = a0; r0_data = d0;
    r1_valid = p1; r1_addr = a1; r1_data = d1;
    @(negedge clk);
    w0 = 1'b0; w1 = 1'b0;
    if (!rst && mr && cyc >= free_at) begin
      if (p0 && p1) begin w0 = ~prio; w1 = prio; end
      else begin w0 = p0; w1 = p1; end
    end
    if (r0_ready || r1_ready) begin
      acc_cyc.push_back(cyc);
      acc_win.push_back(r1_ready);
    end
    check("r0_ready", DATA_W'(r0_ready), DATA_W'(w0));
    check("r1_ready", DATA_W'(r1_ready), DATA_W'(w1));
    check("m_write_ram", DATA_W'(m_write_ram), DATA_W'(exp_ram && !rst));
    check("err_range", DATA_W'(err_range), DATA_W'(exp_err && !rst));
    check("m_write_data", m_write_data, exp_data);
    check("m_write_address", DATA_W'(m_write_address), DATA_W'(exp_addr));
    check("grant_id", DATA_W'(grant_id), DATA_W'(exp_gid));
    check("wr_count", DATA_W'(wr_count), DATA_W'(exp_cnt));
    if (rst) begin
      exp_ram = 1'b0; exp_err = 1'b0; exp_gid = 1'b0; exp_cnt = '0;
      exp_data = '0; exp_addr = '0; prio = 1'b0; free_at = cyc + 1;
    end else begin
      exp_ram = 1'b0; exp_err = 1'b0;
      if (w0 || w1) begin
        win   = w1;
        a     = win ? a1 : a0;
        legal = (a < LIMIT) && (a % 16 == 0);
        if (legal) begin
          exp_ram  = 1'b1;
          exp_data = win ? d1 : d0;
          exp_addr = a;
          exp_cnt  = exp_cnt + 16'd1;
          free_at  = cyc + PERIOD;
        end else begin
          exp_err = 1'b1;
          free_at = cyc + 2;
        end
        exp_gid = win;
        prio    = ~win;
        if (win) begin
          if (hold1) d1 = rnd_data(); else p1 = 1'b0;
        end else begin
          if (hold0) d0 = rnd_data(); else p0 = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to_idle();
    while (cyc < free_at) tick();
  endtask

  initial begin
    int base, t;
    reset = 1'b1; mem_ready = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_data = '0; r1_data = '0;
    @(posedge clk);
    #1;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Single r0 write to address 0, then the next accept exactly one period later.
    base = acc_cyc.size(); t = cyc;
    p0 = 1'b1; a0 = 32'h0; d0 = {32{24'h3D11AE}};
    tick();
    check("t1_strobe", DATA_W'(m_write_ram), DATA_W'(1'b1));
    check("t1_addr", DATA_W'(m_write_address), DATA_W'(32'h0));
    check("t1_data", m_write_data, {32{24'h3D11AE}});
    check("t1_wr_count", DATA_W'(wr_count), DATA_W'(16'd1));
    p0 = 1'b1; a0 = 32'h10; d0 = rnd_data();
    repeat (PERIOD) tick();
    check_acc("t1_first", base, t, 1'b0);
    check_acc("t1_next", base + 1, t + PERIOD, 1'b0);

    // Both requesters held valid: grants alternate, one period apart.
    run_to_idle();
    base = acc_cyc.size(); t = cyc;
    hold0 = 1'b1; hold1 = 1'b1;
    p0 = 1'b1; a0 = 32'h10; d0 = rnd_data();
    p1 = 1'b1; a1 = 32'h20; d1 = rnd_data();
    repeat (4 * PERIOD) tick();
    hold0 = 1'b0; hold1 = 1'b0; p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 4; i++) check_acc("t2_grant", base + i, t + i * PERIOD, (i % 2) == 0);

    // r1 out of range: consumed, err pulse, no strobe, pending r0 taken two cycles later.
    run_to_idle();
    base = acc_cyc.size(); t = cyc;
    p1 = 1'b1; a1 = 32'd393216; d1 = rnd_data();
    tick();
    check("t3_err", DATA_W'(err_range), DATA_W'(1'b1));
    check("t3_no_strobe", DATA_W'(m_write_ram), DATA_W'(1'b0));
    p0 = 1'b1; a0 = 32'h40; d0 = rnd_data();
    repeat (2) tick();
    check_acc("t3_bad", base, t, 1'b1);
    check_acc("t3_r0", base + 1, t + 2, 1'b0);

    // Misaligned r0: err pulse, address output keeps the last legal write.
    run_to_idle();
    p0 = 1'b1; a0 = 32'h18; d0 = rnd_data();
    tick();
    check("t4_err", DATA_W'(err_range), DATA_W'(1'b1));
    check("t4_addr_held", DATA_W'(m_write_address), DATA_W'(32'h40));
    tick();

    // mem_ready low blocks accepts; ready follows mem_ready in the same cycle.
    run_to_idle();
    base = acc_cyc.size();
    mr = 1'b0; p0 = 1'b1; a0 = 32'h80; d0 = rnd_data();
    repeat (50) tick();
    check("t5_blocked", DATA_W'(acc_cyc.size()), DATA_W'(base));
    mr = 1'b1; t = cyc;
    tick();
    check_acc("t5_release", base, t, 1'b0);

    // Reset in gap cycle 40 after an r1 grant; the first grant afterwards goes to r0.
    run_to_idle();
    p1 = 1'b1; a1 = 32'h100; d1 = rnd_data();
    tick();
    repeat (40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_ram", DATA_W'(m_write_ram), DATA_W'(1'b0));
    check("t6_err", DATA_W'(err_range), DATA_W'(1'b0));
    check("t6_data", m_write_data, '0);
    check("t6_addr", DATA_W'(m_write_address), DATA_W'(32'h0));
    check("t6_gid", DATA_W'(grant_id), DATA_W'(1'b0));
    check("t6_cnt", DATA_W'(wr_count), DATA_W'(16'd0));
    base = acc_cyc.size(); t = cyc;
    p0 = 1'b1; a0 = 32'h200; d0 = rnd_data();
    p1 = 1'b1; a1 = 32'h300; d1 = rnd_data();
    tick();
    check_acc("t6_first", base, t, 1'b0);

    // Random traffic with withdrawals, mem_ready drops and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if (!p0 && $urandom_range(0, 3) == 0) begin
        p0 = 1'b1; a0 = rnd_addr(); d0 = rnd_data();
      end else if (p0 && $urandom_range(0, 59) == 0) begin
        p0 = 1'b0;
      end
      if (!p1 && $urandom_range(0, 3) == 0) begin
        p1 = 1'b1; a1 = rnd_addr(); d1 = rnd_data();
      end else if (p1 && $urandom_range(0, 59) == 0) begin
        p1 = 1'b0;
      end
      mr  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
